// File: rtl/aes_pkg.sv
// Shared constants, FSM encoding and GF(2^8) helpers for the AES-256 inverse cipher.
// State bytes are column-major: s[r][c] is byte r+4c, and byte 0 is bits [127:120].
package aes_pkg;
   localparam int NR = 14;
   localparam int NB = 4;

   typedef enum logic [1:0] {ST_IDLE, ST_ROUND, ST_FINAL} state_t;

   function automatic int bidx(input int r, input int c);
      return r + NB*c;
   endfunction

   function automatic logic [7:0] get_byte(input logic [127:0] s, input int n);
      return s[127-8*n -: 8];
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // Constant multiplies built from the x2/x4/x8 xtime chain.
   function automatic logic [7:0] mul09(input logic [7:0] b);
      logic [7:0] x2, x4, x8;
      x2 = xtime(b); x4 = xtime(x2); x8 = xtime(x4);
      return x8 ^ b;
   endfunction

   function automatic logic [7:0] mul0b(input logic [7:0] b);
      logic [7:0] x2, x4, x8;
      x2 = xtime(b); x4 = xtime(x2); x8 = xtime(x4);
      return x8 ^ x2 ^ b;
   endfunction

   function automatic logic [7:0] mul0d(input logic [7:0] b);
      logic [7:0] x2, x4, x8;
      x2 = xtime(b); x4 = xtime(x2); x8 = xtime(x4);
      return x8 ^ x4 ^ b;
   endfunction

   function automatic logic [7:0] mul0e(input logic [7:0] b);
      logic [7:0] x2, x4, x8;
      x2 = xtime(b); x4 = xtime(x2); x8 = xtime(x4);
      return x8 ^ x4 ^ x2;
   endfunction
endpackage

// File: rtl/aes_inv_sbox.sv
// Combinational AES inverse S-box, one byte in, one byte out.
module aes_inv_sbox (
   input  logic [7:0] i_byte,
   output logic [7:0] o_byte
);
   localparam logic [0:255][7:0] INV_SBOX = {
      128'h52096ad53036a538bf40a39e81f3d7fb,
      128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e,
      128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692,
      128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506,
      128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673,
      128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b,
      128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f,
      128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961,
      128'h172b047eba77d626e169146355210c7d
   };

   assign o_byte = INV_SBOX[i_byte];
endmodule

// File: rtl/aes256_inv_cipher.sv
// Iterative AES-256 inverse cipher: one round per clock, round keys are fetched
// from an external store by driving rk_idx and reading roundkey in the same cycle.
module aes256_inv_cipher #(
   parameter int NR       = 14,
   parameter int RK_IDX_W = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [127:0]        data,
   output logic                ready,
   output logic [RK_IDX_W-1:0] rk_idx,
   input  logic [127:0]        roundkey,
   output logic [127:0]        dataout,
   output logic                done
);
   import aes_pkg::*;

   localparam logic [RK_IDX_W-1:0] LAST_IDX  = RK_IDX_W'(NR);
   localparam logic [RK_IDX_W-1:0] FIRST_CNT = RK_IDX_W'(NR-1);
   localparam logic [RK_IDX_W-1:0] ONE       = RK_IDX_W'(1);

   state_t              r_state, w_state_nxt;
   logic [RK_IDX_W-1:0] r_cnt;
   logic [127:0]        r_st, r_dataout;
   logic                r_done;
   logic [127:0]        w_isr, w_isb, w_ark, w_imc;

   function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int r = 0; r < NB; r++)
         for (int c = 0; c < NB; c++)
            o[127-8*bidx(r, (c+r)%NB) -: 8] = get_byte(s, bidx(r, c));
      return o;
   endfunction

   function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0]   a0, a1, a2, a3;
      o = '0;
      for (int c = 0; c < NB; c++) begin
         a0 = get_byte(s, bidx(0, c));
         a1 = get_byte(s, bidx(1, c));
         a2 = get_byte(s, bidx(2, c));
         a3 = get_byte(s, bidx(3, c));
         o[127-8*bidx(0, c) -: 8] = mul0e(a0) ^ mul0b(a1) ^ mul0d(a2) ^ mul09(a3);
         o[127-8*bidx(1, c) -: 8] = mul09(a0) ^ mul0e(a1) ^ mul0b(a2) ^ mul0d(a3);
         o[127-8*bidx(2, c) -: 8] = mul0d(a0) ^ mul09(a1) ^ mul0e(a2) ^ mul0b(a3);
         o[127-8*bidx(3, c) -: 8] = mul0b(a0) ^ mul0d(a1) ^ mul09(a2) ^ mul0e(a3);
      end
      return o;
   endfunction

   assign w_isr = inv_shift_rows(r_st);

   for (genvar gi = 0; gi < 16; gi++) begin : g_sbox
      aes_inv_sbox u_sbox (
         .i_byte (w_isr[127-8*gi -: 8]),
         .o_byte (w_isb[127-8*gi -: 8])
      );
   end

   // The final round reuses w_ark and simply skips InvMixColumns.
   assign w_ark = w_isb ^ roundkey;
   assign w_imc = inv_mix_columns(w_ark);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      ready       = 1'b0;
      rk_idx      = '0;
      case (r_state)
         ST_IDLE: begin
            ready  = 1'b1;
            rk_idx = LAST_IDX;
            if (start) w_state_nxt = ST_ROUND;
         end
         ST_ROUND: begin
            rk_idx = r_cnt;
            if (r_cnt == ONE) w_state_nxt = ST_FINAL;
         end
         ST_FINAL: begin
            rk_idx      = '0;
            w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt     <= FIRST_CNT;
         r_st      <= '0;
         r_dataout <= '0;
         r_done    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_st  <= data ^ roundkey;
                  r_cnt <= FIRST_CNT;
               end
            end
            ST_ROUND: begin
               r_st  <= w_imc;
               r_cnt <= r_cnt - ONE;
            end
            ST_FINAL: begin
               r_dataout <= w_ark;
               r_done    <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign dataout = r_dataout;
   assign done    = r_done;
endmodule

// File: tb/tb_aes256_inv_cipher.sv
// Directed-vector and reference-model bench for the AES-256 inverse cipher.
module tb_aes256_inv_cipher;
   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [127:0] data;
   logic         ready;
   logic [3:0]   rk_idx;
   logic [127:0] roundkey;
   logic [127:0] dataout;
   logic         done;

   logic [127:0] ks  [0:15];
   logic [127:0] sch [0:14];
   logic [7:0]   fsb [0:255];
   int total = 0;
   int bad   = 0;

   localparam logic [255:0] C3KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] C3CT  = 128'h8ea2b7ca516745bfeafc49904b496089;
   localparam logic [127:0] C3PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] ZCT   = 128'hdc95c078a2408989ad48a21492842087;

   typedef struct {
      string        name;
      logic [255:0] key;
      logic [127:0] ct;
      logic [127:0] pt;
   } vec_t;
   vec_t vecs [3];

   always #5 clk = ~clk;
   assign roundkey = ks[rk_idx];

   aes256_inv_cipher #(.NR(14), .RK_IDX_W(4)) dut (
      .clk(clk), .rst(rst), .start(start), .data(data), .ready(ready),
      .rk_idx(rk_idx), .roundkey(roundkey), .dataout(dataout), .done(done)
   );

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic chk_n(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = 8'h00; x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
      return (x << n) | (x >> (8 - n));
   endfunction

   // Forward S-box from the field inverse plus affine map.
   task automatic build_sbox();
      for (int a = 0; a < 256; a++) begin
         logic [7:0] inv;
         inv = 8'h00;
         for (int b = 1; b < 256; b++)
            if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
         fsb[a] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [31:0] subw(input logic [31:0] w);
      return {fsb[w[31:24]], fsb[w[23:16]], fsb[w[15:8]], fsb[w[7:0]]};
   endfunction

   task automatic expand(input logic [255:0] key);
      logic [31:0] w [0:59];
      logic [31:0] t;
      logic [7:0]  rc;
      for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
      rc = 8'h01;
      for (int i = 8; i < 60; i++) begin
         t = w[i-1];
         if (i % 8 == 0) begin
            t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            rc = gmul(rc, 8'h02);
         end else if (i % 8 == 4) begin
            t = subw(t);
         end
         w[i] = w[i-8] ^ t;
      end
      for (int r = 0; r < 15; r++) sch[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   task automatic load_ks();
      for (int r = 0; r < 15; r++) ks[r] = sch[r];
      ks[15] = '0;
   endtask

   function automatic logic [127:0] encrypt(input logic [127:0] p);
      logic [127:0] s, t;
      logic [7:0]   a0, a1, a2, a3;
      s = p ^ sch[0];
      for (int r = 1; r <= 14; r++) begin
         for (int n = 0; n < 16; n++) t[127-8*n -: 8] = fsb[s[127-8*n -: 8]];
         for (int rr = 0; rr < 4; rr++)
            for (int c = 0; c < 4; c++)
               s[127-8*(rr+4*c) -: 8] = t[127-8*(rr+4*((c+rr)%4)) -: 8];
         if (r != 14) begin
            for (int c = 0; c < 4; c++) begin
               a0 = s[127-8*(4*c) -: 8];   a1 = s[127-8*(4*c+1) -: 8];
               a2 = s[127-8*(4*c+2) -: 8]; a3 = s[127-8*(4*c+3) -: 8];
               s[127-8*(4*c)   -: 8] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
               s[127-8*(4*c+1) -: 8] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
               s[127-8*(4*c+2) -: 8] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
               s[127-8*(4*c+3) -: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
            end
         end
         s = s ^ sch[r];
      end
      return s;
   endfunction

   // Start at the current cycle T and expect done with the plaintext at T+15.
   task automatic run_block(input string name, input logic [127:0] ct, input logic [127:0] exp);
      int lat;
      start = 1'b1; data = ct;
      tick();
      start = 1'b0;
      lat = 1;
      while (!done && lat < 20) begin
         tick();
         lat++;
      end
      chk_n({name, " latency"}, lat, 15);
      chk({name, " dataout"}, dataout, exp);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [255:0] rkey;
      logic [127:0] rpt, rct;

      vecs[0] = '{"fips_c3", C3KEY, C3CT, C3PT};
      vecs[1] = '{"zero_key", 256'h0, ZCT, 128'h0};
      vecs[2] = '{"sp800_38a", 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4,
                  128'hf3eed1bdb5d2a03c064b5a7e3db181f8, 128'h6bc1bee22e409f96e93d7e117393172a};

      rst = 1'b1; start = 1'b0; data = '0;
      for (int r = 0; r < 16; r++) ks[r] = '0;
      build_sbox();
      repeat (2) @(posedge clk);
      #1;
      chk_n("reset ready", int'(ready), 1);
      chk_n("reset done", int'(done), 0);
      chk("reset dataout", dataout, 128'h0);
      chk_n("reset rk_idx", int'(rk_idx), 14);
      rst = 1'b0;
      tick();

      for (int i = 0; i < 3; i++) begin
         expand(vecs[i].key);
         load_ks();
         run_block(vecs[i].name, vecs[i].ct, vecs[i].pt);
      end

      // Round-key index walk and single-cycle done pulse.
      expand(C3KEY); load_ks();
      tick();
      chk_n("idle rk_idx", int'(rk_idx), 14);
      start = 1'b1; data = C3CT;
      tick();
      start = 1'b0;
      for (int k = 1; k <= 14; k++) begin
         chk_n($sformatf("rk_idx T+%0d", k), int'(rk_idx), (k <= 13) ? 14 - k : 0);
         chk_n($sformatf("busy ready T+%0d", k), int'(ready), 0);
         chk_n($sformatf("busy done T+%0d", k), int'(done), 0);
         tick();
      end
      chk_n("seq done T+15", int'(done), 1);
      chk_n("seq ready T+15", int'(ready), 1);
      chk("seq dataout", dataout, C3PT);
      tick();
      chk_n("seq done T+16", int'(done), 0);

      // Back-to-back: start held high while busy, second block accepted at T+15.
      start = 1'b1; data = C3CT;
      tick();
      data = ZCT;
      for (int k = 1; k <= 14; k++) begin
         chk_n($sformatf("b2b ready T+%0d", k), int'(ready), 0);
         chk_n($sformatf("b2b done T+%0d", k), int'(done), 0);
         tick();
      end
      chk_n("b2b first done", int'(done), 1);
      chk("b2b first dataout", dataout, C3PT);
      chk_n("b2b ready T+15", int'(ready), 1);
      expand(256'h0); load_ks();
      tick();
      start = 1'b0;
      for (int k = 16; k <= 29; k++) begin
         chk_n($sformatf("b2b done T+%0d", k), int'(done), 0);
         chk($sformatf("b2b hold T+%0d", k), dataout, C3PT);
         tick();
      end
      chk_n("b2b second done", int'(done), 1);
      chk("b2b second dataout", dataout, 128'h0);
      tick();

      // Reset in the middle of a block.
      expand(C3KEY); load_ks();
      start = 1'b1; data = C3CT;
      tick();
      start = 1'b0;
      repeat (6) tick();
      rst = 1'b1;
      #1;
      chk_n("midrst ready", int'(ready), 1);
      chk_n("midrst done", int'(done), 0);
      chk("midrst dataout", dataout, 128'h0);
      chk_n("midrst rk_idx", int'(rk_idx), 14);
      @(posedge clk); #1;
      rst = 1'b0;
      begin
         int seen;
         seen = 0;
         for (int k = 0; k < 12; k++) begin
            if (done) seen++;
            tick();
         end
         chk_n("midrst no done", seen, 0);
      end
      run_block("after_rst", C3CT, C3PT);

      // Random key/plaintext pairs through the forward reference model.
      for (int n = 0; n < 1000; n++) begin
         rkey = {$urandom(), $urandom(), $urandom(), $urandom(),
                 $urandom(), $urandom(), $urandom(), $urandom()};
         rpt  = {$urandom(), $urandom(), $urandom(), $urandom()};
         expand(rkey); load_ks();
         rct = encrypt(rpt);
         run_block($sformatf("rand%0d", n), rct, rpt);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/aes256_inv_cipher.md
Name: aes256_inv_cipher

Overview:
Iterative AES-256 decryption core (FIPS-197 inverse cipher). It executes one round per clock and is the receive-side counterpart of the encrypt datapath that is built around the Addroundkey XOR stage. Round keys are not expanded locally. The core drives a round index to an external key-schedule store, which returns that round's 128-bit key combinationally in the same cycle. Start/done handshake to the surrounding controller.

Parameters:
NR, 14, number of rounds (fixed for AES-256; sizes the round counter; other values unsupported)
RK_IDX_W, 4, width of round-key index

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-high
start  input  1  request to decrypt data; accepted only when ready=1
data  input  128  ciphertext block, sampled in acceptance cycle
ready  output  1  core idle and able to accept start
rk_idx  output  4  round-key index requested from key store (0..14)
roundkey  input  128  key for rk_idx, valid same cycle (combinational lookup)
dataout  output  128  plaintext block, held until next completion
done  output  1  one-cycle pulse when dataout updated

Behaviour:
- Interface fixed: one clock (clk); rst asynchronous, active-high.
- Byte order per FIPS-197: byte 0 = bits [127:120]; state s[r][c] = byte r+4c (column-major).
- Reset values: ready=1, done=0, dataout=0, rk_idx=14, FSM=IDLE, round counter=13, internal state register=0.
- FSM states: IDLE, ROUND, FINAL.
- IDLE:
  - ready=1, rk_idx=14.
  - On start=1 (cycle T), register st <= data ^ roundkey(14), set counter=13, and go to ROUND.
- ROUND:
  - ready=0, rk_idx=counter.
  - Each cycle: st <= InvMixColumns(InvSubBytes(InvShiftRows(st)) ^ roundkey).
  - Counter decrements. Leave for FINAL after the counter=1 cycle. Occupies T+1..T+13.
- FINAL (T+14):
  - rk_idx=0.
  - dataout <= InvSubBytes(InvShiftRows(st)) ^ roundkey.
  - done <= 1. Go to IDLE.
- Timing: done=1 and new dataout visible in cycle T+15; ready=1 again in T+15.
  - Back-to-back start in T+15 is accepted, giving throughput of 1 block / 15 cycles.
- start while ready=0: ignored, with no queuing and no effect on the running block.
- done is high exactly one cycle per accepted block. dataout is stable otherwise.
- rst asserted mid-operation: immediate abort, return to reset values. No done for the aborted block.
- The AddRoundKey step is a pure 128-bit XOR. InvMixColumns uses GF(2^8) multiply by 0e/0b/0d/09 with polynomial 0x11b, via xtime chains with no multipliers.
- The final round omits InvMixColumns.
- Everything is combinational between state register and next-state; there are no multicycle paths.

Decomposition:
- Package aes_pkg: NR=14, NB=4, state byte-index helper functions, the xtime function, FSM state encoding constants.
- One sub-module, aes_inv_sbox: 8-bit combinational inverse S-box lookup. It is instantiated 16× for InvSubBytes.
- InvShiftRows and InvMixColumns stay as functions or combinational logic inside the core.

Test Plan:
- FIPS-197 C.3 vector: key store loaded with the schedule of key 000102…1f, data=8ea2b7ca516745bfeafc49904b496089, start at T -> done at T+15, dataout=00112233445566778899aabbccddeeff.
- All-zero key schedule, data=dc95c078a2408989ad48a21492842087 -> dataout=0000…0000 after 15 cycles.
- rk_idx sequence check: after start at T, rk_idx shows 14 at T, then 13,12,…,1 over T+1..T+13, then 0 at T+14. done is a single-cycle pulse.
- Back-to-back: second start (zero-key vector) held high from T+1 through T+15 -> ignored while busy, accepted at T+15, second done at T+30 with correct plaintext; first dataout held between completions.
- Reset mid-operation: assert rst at T+7 -> ready=1, done=0, dataout=0 immediately. A new C.3 start after release completes correctly in 15 cycles.
- Randomized: 1000 random key/block pairs against a reference encrypt model -> decrypt(encrypt(p))=p for every block.
